mem_bus_initiator: RTL and testbench

Initiator side of the MOV/MOC memory handshake used by ram256x8. It accepts single-beat load/store requests from the control path over a valid/ready port and drives MOV, RW, typeData, address and write data toward the memory. It then waits for MOC and returns read data or an error to the requester. It sits between the datapath (MAR/MDR side) and the memory, and replaces ad-hoc MOV sequencing in control states.

---
 rtl/mem_bus_initiator_if.sv | 23 ++
 rtl/mem_bus_initiator.sv | 207 ++++++++++++++++++++
 tb/tb_mem_bus_initiator.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_initiator_if.sv
// MOV/MOC memory bus between mem_bus_initiator (master) and the memory (slave).
interface mem_bus_initiator_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              MOV;
  logic              RW;
  logic [1:0]        typeData;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              MOC;

  modport master (
    output MOV, RW, typeData, mem_addr, mem_wdata,
    input  mem_rdata, MOC
  );

  modport slave (
    input  MOV, RW, typeData, mem_addr, mem_wdata,
    output mem_rdata, MOC
  );
endinterface

// File: rtl/mem_bus_initiator.sv
// Single-beat load/store initiator for the four-phase MOV/MOC memory handshake.
// Optional MOC wait timeout enabled by defining MEM_INIT_TIMEOUT_EN.
module mem_bus_initiator #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
`ifdef MEM_INIT_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_rw,
  input  logic [1:0]          req_type,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  mem_bus_initiator_if.master mem
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                lat_rw_q, lat_rw_d;
  logic [1:0]          type_q, type_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mov_q, mov_d;
  logic                mem_rw_q, mem_rw_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

`ifdef MEM_INIT_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Reserved type, odd halfword or non-word-aligned word is rejected before any bus access.
  function automatic logic is_misaligned(input logic [1:0] t, input logic [1:0] a);
    logic bad;
    case (t)
      2'b00:   bad = 1'b0;
      2'b01:   bad = a[0];
      2'b10:   bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] t, input logic [31:0] d);
    logic [31:0] r;
    case (t)
      2'b00:   r = {24'h000000, d[7:0]};
      2'b01:   r = {16'h0000, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Next-state, request latching and response capture.
  always_comb begin
    state_d     = state_q;
    lat_rw_d    = lat_rw_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef MEM_INIT_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          lat_rw_d    = req_rw;
          type_d      = req_type;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          rsp_rdata_d = {DATA_W{1'b0}};
          if (is_misaligned(req_type, req_addr[1:0])) begin
            rsp_err_d = 1'b1;
            state_d   = ST_RESP;
          end else begin
            rsp_err_d = 1'b0;
            state_d   = ST_ASSERT;
`ifdef MEM_INIT_TIMEOUT_EN
            cnt_d     = CNT_ZERO;
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (mem.MOC) begin
          rsp_rdata_d = lat_rw_q ? load_extend(type_q, mem.mem_rdata) : {DATA_W{1'b0}};
          state_d     = ST_RELEASE;
`ifdef MEM_INIT_TIMEOUT_EN
          cnt_d       = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          rsp_rdata_d = {DATA_W{1'b0}};
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
`else
        end else begin
          state_d = ST_ASSERT;
`endif
        end
      end
      ST_RELEASE: begin
        if (!mem.MOC) begin
          state_d = ST_RESP;
`ifdef MEM_INIT_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          // Memory never released MOC: drop the captured data and report an error.
          rsp_rdata_d = {DATA_W{1'b0}};
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
`else
        end else begin
          state_d = ST_RELEASE;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mov_d       = (state_d == ST_ASSERT);
    mem_rw_d    = (state_d == ST_ASSERT) && lat_rw_d;
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_q     <= ST_IDLE;
      lat_rw_q    <= 1'b0;
      type_q      <= 2'b00;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      mov_q       <= 1'b0;
      mem_rw_q    <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      rsp_err_q   <= 1'b0;
`ifdef MEM_INIT_TIMEOUT_EN
      cnt_q       <= CNT_ZERO;
`endif
    end else begin
      state_q     <= state_d;
      lat_rw_q    <= lat_rw_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mov_q       <= mov_d;
      mem_rw_q    <= mem_rw_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef MEM_INIT_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign mem.MOV       = mov_q;
  assign mem.RW        = mem_rw_q;
  assign mem.typeData  = type_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Directed self-checking bench for mem_bus_initiator with a small MOV/MOC memory responder.
module tb_mem_bus_initiator;

  logic        clk       = 1'b0;
  logic        CLR       = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw    = 1'b0;
  logic [1:0]  req_type  = 2'b00;
  logic [31:0] req_addr  = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        moc_en    = 1'b0;
  logic        moc_force = 1'b0;
  int          moc_delay = 0;
  int          mov_cnt   = 0;
  logic [31:0] mem_data  = 32'h0;

  int          n_tests = 0;
  int          n_fail  = 0;

  logic        snap_taken;
  logic        snap_rw;
  logic [1:0]  snap_type;
  logic [31:0] snap_addr;
  logic [31:0] snap_wdata;
  logic        snap_ready;

  mem_bus_initiator_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_initiator #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK       (clk),
    .CLR       (CLR),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_type  (req_type),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem       (bus)
  );

  always #5 clk = ~clk;

  // Memory raises MOC moc_delay cycles after MOV rises and drops it as soon as MOV falls.
  assign bus.MOC       = moc_force | (moc_en & bus.MOV & (mov_cnt >= moc_delay));
  assign bus.mem_rdata = mem_data;
  always @(posedge clk) mov_cnt <= bus.MOV ? mov_cnt + 1 : 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for its response, hold rsp_ready low for `hold` cycles, then accept.
  task automatic run_txn(input string tag, input logic rw, input logic [1:0] t,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_mov, input int exp_lat, input int hold);
    int lat;
    int movc;
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_type = t; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; movc = 0; snap_taken = 1'b0;
    while (!rsp_valid && lat < 200) begin
      if (bus.MOV) begin
        movc++;
        if (!snap_taken) begin
          snap_taken = 1'b1;
          snap_rw = bus.RW; snap_type = bus.typeData; snap_addr = bus.mem_addr;
          snap_wdata = bus.mem_wdata; snap_ready = req_ready;
        end
      end
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_rsp_seen"}, {31'b0, rsp_valid}, 32'd1);
    check_eq({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check_eq({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    check_eq({tag, "_mov_cycles"}, movc, exp_mov);
    check_eq({tag, "_latency"}, lat, exp_lat);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, {31'b0, rsp_valid}, 32'd1);
      check_eq({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq({tag, "_valid_clr"}, {31'b0, rsp_valid}, 32'd0);
    check_eq({tag, "_ready_back"}, {31'b0, req_ready}, 32'd1);
    check_eq({tag, "_rw_idle"}, {31'b0, bus.RW}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst_mov", {31'b0, bus.MOV}, 32'd0);
    check_eq("rst_rw", {31'b0, bus.RW}, 32'd0);
    check_eq("rst_type", {30'b0, bus.typeData}, 32'd0);
    check_eq("rst_addr", bus.mem_addr, 32'h0);
    check_eq("rst_wdata", bus.mem_wdata, 32'h0);
    check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    CLR = 1'b1;

    // MOC high while idle must not start anything.
    @(negedge clk);
    moc_force = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_moc_mov", {31'b0, bus.MOV}, 32'd0);
    check_eq("idle_moc_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("idle_moc_ready", {31'b0, req_ready}, 32'd1);
    moc_force = 1'b0;

    moc_en = 1'b1;
    moc_delay = 2; mem_data = 32'hE3A01005;
    run_txn("word_rd", 1'b1, 2'b10, 32'h04, 32'h0, 32'hE3A01005, 1'b0, 3, 5, 0);
    check_eq("word_rd_snap_rw", {31'b0, snap_rw}, 32'd1);
    check_eq("word_rd_snap_ready", {31'b0, snap_ready}, 32'd0);

    moc_delay = 1; mem_data = 32'hAABBCCF1;
    run_txn("byte_rd", 1'b1, 2'b00, 32'h07, 32'h0, 32'h000000F1, 1'b0, 2, 4, 0);
    check_eq("byte_rd_snap_type", {30'b0, snap_type}, 32'd0);
    run_txn("half_rd", 1'b1, 2'b01, 32'h06, 32'h0, 32'h0000CCF1, 1'b0, 2, 4, 0);
    check_eq("half_rd_snap_addr", snap_addr, 32'h06);

    moc_delay = 0;
    run_txn("word_wr", 1'b0, 2'b10, 32'h08, 32'h12345678, 32'h0, 1'b0, 1, 3, 0);
    check_eq("word_wr_snap_rw", {31'b0, snap_rw}, 32'd0);
    check_eq("word_wr_snap_type", {30'b0, snap_type}, 32'd2);
    check_eq("word_wr_snap_addr", snap_addr, 32'h08);
    check_eq("word_wr_snap_wdata", snap_wdata, 32'h12345678);

    run_txn("err_word", 1'b1, 2'b10, 32'h02, 32'h0, 32'h0, 1'b1, 0, 1, 0);
    run_txn("err_half", 1'b1, 2'b01, 32'h03, 32'h0, 32'h0, 1'b1, 0, 1, 0);
    run_txn("err_rsvd", 1'b1, 2'b11, 32'h00, 32'h0, 32'h0, 1'b1, 0, 1, 0);

    moc_en = 1'b0;
`ifdef MEM_INIT_TIMEOUT_EN
    run_txn("timeout", 1'b1, 2'b10, 32'h0C, 32'h0, 32'h0, 1'b1, 16, 17, 0);
`else
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_type = 2'b10; req_addr = 32'h0C;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (100) @(negedge clk);
    check_eq("no_timeout_mov", {31'b0, bus.MOV}, 32'd1);
    check_eq("no_timeout_valid", {31'b0, rsp_valid}, 32'd0);
    CLR = 1'b0;
    @(negedge clk);
    CLR = 1'b1;
`endif

    // Reset during the second ASSERT cycle aborts with no response.
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_type = 2'b10; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("abort_mov_pre", {31'b0, bus.MOV}, 32'd1);
    @(negedge clk);
    CLR = 1'b0;
    @(negedge clk);
    CLR = 1'b1;
    check_eq("abort_mov", {31'b0, bus.MOV}, 32'd0);
    check_eq("abort_ready", {31'b0, req_ready}, 32'd1);
    check_eq("abort_valid", {31'b0, rsp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);

    moc_en = 1'b1; moc_delay = 0; mem_data = 32'h0BADF00D;
    run_txn("post_rst_rd", 1'b1, 2'b10, 32'h00, 32'h0, 32'h0BADF00D, 1'b0, 1, 3, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
